// File: rtl/mem_if_pkg.sv
// Shared types for the CPU data-port sram-like interface: access size
// encodings, the queued response entry and the protocol legality check.
package mem_if_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } resp_entry_t;

    localparam int unsigned RESP_W = $bits(resp_entry_t);

    function automatic logic is_proto_err(input logic wr, input logic [1:0] size,
                                          input logic [3:0] wstrb);
        return (size == SIZE_ILLEGAL) || (wr && wstrb == 4'h0) || (!wr && wstrb != 4'h0);
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous FIFO with a combinational head; pointers and count reset
// asynchronously, storage is not reset.
module resp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != FULL_C);
    assign do_pop  = pop && (count != '0);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side sram-like responder: commits writes / samples reads at acceptance,
// returns in-order data_ok after LATENCY cycles with injectable back-pressure.
module data_sram_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    input  logic        stall_addr,
    input  logic        stall_data,
    output logic        proto_err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]          ram [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] idx;
    logic [CW-1:0]        inflight;
    logic                 accept;
    resp_entry_t          acc_entry;
    resp_entry_t          push_e;
    resp_entry_t          head_e;
    logic                 push_v;
    logic                 fifo_empty;
    logic                 unused_addr_bits;

    assign idx              = data_sram_addr[ADDR_BITS+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_BITS+2], data_sram_addr[1:0]};

    assign data_sram_addr_ok = resetn && !stall_addr && (inflight < DEPTH_C);
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign data_sram_data_ok = !fifo_empty && !stall_data;
    assign data_sram_rdata   = (data_sram_data_ok && head_e.is_read) ? head_e.data : '0;

    always_comb begin
        acc_entry         = '0;
        acc_entry.is_read = !data_sram_wr;
        if (!data_sram_wr) begin
            acc_entry.data = ram[idx];
        end
    end

    // Writes commit at acceptance, so any later read sees them in program order.
    always_ff @(posedge clk) begin
        if (accept && data_sram_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    ram[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign push_v = accept;
            assign push_e = acc_entry;
        end else begin : g_pipe
            localparam int unsigned STAGES = LATENCY - 1;
            logic [STAGES-1:0] stage_v;
            resp_entry_t       stage_e [STAGES];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    stage_v <= '0;
                    for (int unsigned i = 0; i < STAGES; i++) begin
                        stage_e[i] <= '0;
                    end
                end else begin
                    stage_v[0] <= accept;
                    stage_e[0] <= acc_entry;
                    for (int unsigned i = 1; i < STAGES; i++) begin
                        stage_v[i] <= stage_v[i-1];
                        stage_e[i] <= stage_e[i-1];
                    end
                end
            end

            assign push_v = stage_v[STAGES-1];
            assign push_e = stage_e[STAGES-1];
        end
    endgenerate

    resp_fifo #(
        .WIDTH(RESP_W),
        .DEPTH(DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push_v),
        .push_data(push_e),
        .pop      (data_sram_data_ok),
        .head     (head_e),
        .empty    (fifo_empty)
    );

    // Counting accepted-but-unanswered requests caps FIFO occupancy at DEPTH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight <= '0;
        end else begin
            case ({accept, data_sram_data_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err <= 1'b0;
        end else if (accept && is_proto_err(data_sram_wr, data_sram_size, data_sram_wstrb)) begin
            proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: directed requests push expected
// responses; a negedge monitor pops and compares on every data_ok.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;
    logic        stall_addr, stall_data;
    logic        proto_err;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_q [$];
    int          ok_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_responder #(
        .ADDR_BITS(10),
        .LATENCY  (2),
        .DEPTH    (4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .data_sram_req    (req),
        .data_sram_wr     (wr),
        .data_sram_size   (size),
        .data_sram_wstrb  (wstrb),
        .data_sram_addr   (addr),
        .data_sram_wdata  (wdata),
        .data_sram_addr_ok(addr_ok),
        .data_sram_data_ok(data_ok),
        .data_sram_rdata  (rdata),
        .stall_addr       (stall_addr),
        .stall_data       (stall_data),
        .proto_err        (proto_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (resetn) begin
            if (data_ok) begin
                ok_cyc.push_back(cyc);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_data_ok: rdata 0x%08h with nothing outstanding (cycle %0d)", rdata, cyc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        bad++;
                        $display("FAIL rdata: got 0x%08h expected 0x%08h (cycle %0d)", rdata, e, cyc);
                    end
                end
            end else if (rdata !== 32'h0) begin
                total++;
                bad++;
                $display("FAIL rdata_idle: got 0x%08h expected 0x00000000 (cycle %0d)", rdata, cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp, output int acc);
        req = 1'b1; wr = w; size = sz; wstrb = st; addr = a; wdata = wd;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (addr_ok) begin
                acc = cyc;
                exp_q.push_back(exp);
                break;
            end
        end
        if (acc < 0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: addr 0x%08h never accepted", a);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, a5, m, r;
        int acc [4];

        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2; wstrb = 4'h0;
        addr = '0; wdata = '0; stall_addr = 1'b0; stall_data = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_addr_ok", 32'(addr_ok), 32'd0);
        check("reset_data_ok", 32'(data_ok), 32'd0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_proto_err", 32'(proto_err), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Write then read, timing N+2 / N+3
        ok_cyc.delete();
        issue(1'b1, 2'd2, 4'hF, 32'h40, 32'h12345678, 32'h0, n);
        issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 32'h12345678, r);
        check("rd_after_wr_accept", 32'(r), 32'(n + 1));
        wait_drain();
        check("wr_rd_ok_count", 32'(ok_cyc.size()), 32'd2);
        if (ok_cyc.size() == 2) begin
            check("wr_data_ok_cycle", 32'(ok_cyc[0]), 32'(n + 2));
            check("rd_data_ok_cycle", 32'(ok_cyc[1]), 32'(n + 3));
        end

        // Byte strobe into lane 2, then address wrap past RAM depth
        issue(1'b1, 2'd0, 4'h4, 32'h42, 32'h00AB0000, 32'h0, n);
        issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 32'h12AB5678, n);
        issue(1'b1, 2'd2, 4'hF, 32'h1000, 32'hCAFEF00D, 32'h0, n);
        issue(1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, n);
        wait_drain();
        check("proto_err_legal", 32'(proto_err), 32'd0);

        // Full: 4 accepted under stall_data, 5th held off until a slot frees
        stall_data = 1'b1;
        ok_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 32'h12AB5678, acc[k]);
        end
        check("full_accepts_consecutive", 32'(acc[3]), 32'(acc[0] + 3));
        req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_addr_ok_low", 32'(addr_ok), 32'd0);
        end
        @(posedge clk);
        #1;
        stall_data = 1'b0;
        m = cyc;
        issue(1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, a5);
        check("full_fifth_accept_cycle", 32'(a5), 32'(m + 1));
        wait_drain();
        check("full_ok_count", 32'(ok_cyc.size()), 32'd5);
        if (ok_cyc.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("full_ok_cycle", 32'(ok_cyc[k]), 32'(m + k));
            end
        end

        // Address stall: request held but never accepted
        ok_cyc.delete();
        stall_addr = 1'b1;
        req = 1'b1; wr = 1'b1; size = 2'd2; wstrb = 4'hF; addr = 32'h40; wdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_addr_ok_low", 32'(addr_ok), 32'd0);
        end
        check("stall_no_response", 32'(ok_cyc.size()), 32'd0);
        @(posedge clk);
        #1;
        stall_addr = 1'b0;
        r = cyc;
        issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 32'h12AB5678, n);
        check("stall_release_accept", 32'(n), 32'(r));
        wait_drain();

        // Protocol: size 3 sets sticky flag
        issue(1'b0, 2'd3, 4'h0, 32'h40, 32'h0, 32'h12AB5678, n);
        @(negedge clk);
        check("proto_size3", 32'(proto_err), 32'd1);
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 4'h0, 32'h0, 32'h0, 32'hCAFEF00D, n);
        wait_drain();
        check("proto_sticky", 32'(proto_err), 32'd1);

        // Reset with three responses queued
        stall_data = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 32'h12AB5678, n);
        end
        #1;
        resetn = 1'b0;
        #1;
        check("midrst_data_ok", 32'(data_ok), 32'd0);
        check("midrst_addr_ok", 32'(addr_ok), 32'd0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_proto_err", 32'(proto_err), 32'd0);
        exp_q.delete();
        ok_cyc.delete();
        stall_data = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_stale", 32'(ok_cyc.size()), 32'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 4'h0, 32'h40, 32'h0, 32'h12AB5678, n);
        wait_drain();

        // Protocol: write with no strobes, then read with strobes
        issue(1'b1, 2'd2, 4'h0, 32'h80, 32'h0, 32'h0, n);
        wait_drain();
        check("proto_wr_nostrb", 32'(proto_err), 32'd1);
        resetn = 1'b0;
        #1;
        check("proto_cleared", 32'(proto_err), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 2'd2, 4'hF, 32'h0, 32'h0, 32'hCAFEF00D, n);
        wait_drain();
        check("proto_rd_strb", 32'(proto_err), 32'd1);

        check("final_outstanding", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
